dieukhien_nut: RTL and testbench



---
 rtl/dieukhien_nut.sv | 191 +++++++++++++++++++
 tb/tb_dieukhien_nut.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dieukhien_nut.sv
// dieukhien_nut - front-panel button stage for the LED chaser.
//
// Two raw push-buttons are synchronised and debounced, one FSM per button.
// Each clean press advances a 2-bit wrap-around register:
//   btn_speed -> Select (clock-mux select)
//   btn_mode  -> MODE   (mode-decoder select)
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active low
//   btn_speed  raw push-button, active high, advances Select
//   btn_mode   raw push-button, active high, advances MODE
//   lock       1 = accepted presses are discarded, registers hold
//   Select     registered 2-bit speed select
//   MODE       registered 2-bit mode select
//   changed    one-cycle strobe in the cycle after Select/MODE changed
//
// Build option:
//   AUTO_CYCLE_EN  adds an idle timer that advances MODE every
//                  AUTO_CYCLES unlocked cycles without a button accept.

// Synchroniser + debounce FSM for one button. accept_o is combinational and
// high for the single cycle in which PRESS_WAIT completes.
module dieukhien_nut_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic accept_o
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } st_e;

    logic          s1_q, s2_q;
    st_e           state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State register, synchroniser flops included.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q)              state_d = IDLE;
                else if (cnt_q == CMAX) state_d = PRESSED;
                else                    cnt_d   = cnt_q + CW'(1);
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s2_q)               state_d = PRESSED;
                else if (cnt_q == CMAX) state_d = IDLE;
                else                    cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Output: accept on the PRESS_WAIT -> PRESSED transition only, so a held
    // button yields exactly one accept.
    always_comb begin
        accept_o = (state_q == PRESS_WAIT) && s2_q && (cnt_q == CMAX);
    end
endmodule

module dieukhien_nut #(
    parameter int DEB_CYCLES  = 500000,
    parameter int AUTO_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_speed,
    input  logic       btn_mode,
    input  logic       lock,
    output logic [1:0] Select,
    output logic [1:0] MODE,
    output logic       changed
);
    if (DEB_CYCLES < 2) begin : g_chk_deb
        $error("DEB_CYCLES must be at least 2");
    end
    if (AUTO_CYCLES < 2) begin : g_chk_auto
        $error("AUTO_CYCLES must be at least 2");
    end

    logic [1:0] btn_w;   // [0] speed, [1] mode
    logic [1:0] acc;

    assign btn_w = {btn_mode, btn_speed};

    for (genvar g = 0; g < 2; g++) begin : g_deb
        dieukhien_nut_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk      (clk),
            .reset    (reset),
            .btn_i    (btn_w[g]),
            .accept_o (acc[g])
        );
    end

    logic       sel_inc, mode_btn_inc, mode_inc, timeout;
    logic [1:0] sel_q, sel_d, mode_q, mode_d;
    logic       changed_q, changed_d;

    // Accepts are consumed while locked; the FSMs advance regardless.
    assign sel_inc      = acc[0] & ~lock;
    assign mode_btn_inc = acc[1] & ~lock;

`ifdef AUTO_CYCLE_EN
    localparam int TW = $clog2(AUTO_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(AUTO_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Timer freezes while locked, so a lock never triggers an auto step.
    assign timeout = ~lock && (timer_q == TMAX);

    always_comb begin
        timer_d = timer_q;
        if (!lock) begin
            if (timeout || sel_inc || mode_btn_inc) timer_d = '0;
            else                                    timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // A button accept coinciding with a timeout still steps MODE only once.
    assign mode_inc = mode_btn_inc | timeout;

    always_comb begin
        sel_d     = sel_inc  ? sel_q  + 2'd1 : sel_q;
        mode_d    = mode_inc ? mode_q + 2'd1 : mode_q;
        // Any increment is a real change because the registers wrap mod 4.
        changed_d = sel_inc | mode_inc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q     <= 2'd0;
            mode_q    <= 2'd0;
            changed_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            mode_q    <= mode_d;
            changed_q <= changed_d;
        end
    end

    assign Select  = sel_q;
    assign MODE    = mode_q;
    assign changed = changed_q;
endmodule

// File: tb/tb_dieukhien_nut.sv
module tb_dieukhien_nut;
    logic       clk = 1'b0;
    logic       reset, btn_speed, btn_mode, lock;
    logic [1:0] Select, MODE;
    logic       changed;

    int checks = 0;
    int errors = 0;
    int first, nchg;

    dieukhien_nut #(.DEB_CYCLES(4), .AUTO_CYCLES(50)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_speed (btn_speed),
        .btn_mode  (btn_mode),
        .lock      (lock),
        .Select    (Select),
        .MODE      (MODE),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n edges (index 0 = first edge after the call); report the index of
    // the first edge after which changed was seen high and the pulse count.
    task automatic run(input int n, output int f, output int c);
        f = -1;
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (changed) begin
                c++;
                if (f < 0) f = i;
            end
        end
    endtask

    // Ticks until changed is seen; returns tick count, -1 on timeout.
    task automatic wait_chg(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (changed) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b0; btn_speed = 1'b0; btn_mode = 1'b0; lock = 1'b0;
        repeat (3) tick();
        chk("rst_select", Select, 0);
        chk("rst_mode", MODE, 0);
        chk("rst_changed", changed, 0);
        reset = 1'b1;

`ifndef AUTO_CYCLE_EN
        // Idle after reset.
        run(20, first, nchg);
        chk("idle_nchg", nchg, 0);
        chk("idle_select", Select, 0);
        chk("idle_mode", MODE, 0);

        // First speed press, held 30 cycles.
        btn_speed = 1'b1;
        run(30, first, nchg);
        chk("spd1_edge", first, 6);
        chk("spd1_nchg", nchg, 1);
        chk("spd1_select", Select, 1);
        btn_speed = 1'b0;
        run(10, first, nchg);
        chk("spd1_rel_nchg", nchg, 0);

        // Three more presses: 2, 3, then wrap to 0.
        for (int k = 2; k <= 4; k++) begin
            btn_speed = 1'b1;
            run(12, first, nchg);
            chk("spdN_nchg", nchg, 1);
            chk("spdN_select", Select, k % 4);
            btn_speed = 1'b0;
            run(10, first, nchg);
        end

        // Mode button bouncing every 2 cycles, then steady.
        for (int k = 0; k < 5; k++) begin
            btn_mode = 1'b1;
            run(2, first, nchg);
            chk("bnc_nchg_hi", nchg, 0);
            btn_mode = 1'b0;
            run(2, first, nchg);
            chk("bnc_nchg_lo", nchg, 0);
        end
        chk("bnc_mode", MODE, 0);
        btn_mode = 1'b1;
        run(12, first, nchg);
        chk("mode1_edge", first, 6);
        chk("mode1_nchg", nchg, 1);
        chk("mode1_mode", MODE, 1);
        btn_mode = 1'b0;
        run(10, first, nchg);

        // Short release glitch while held returns to PRESSED, no new accept.
        btn_speed = 1'b1;
        run(12, first, nchg);
        chk("glt_press_select", Select, 1);
        btn_speed = 1'b0;
        run(2, first, nchg);
        btn_speed = 1'b1;
        run(10, first, nchg);
        chk("glt_nchg", nchg, 0);
        chk("glt_select", Select, 1);
        btn_speed = 1'b0;
        run(10, first, nchg);

        // Both buttons on the same edge: one changed pulse.
        btn_speed = 1'b1; btn_mode = 1'b1;
        run(12, first, nchg);
        chk("both_edge", first, 6);
        chk("both_nchg", nchg, 1);
        chk("both_select", Select, 2);
        chk("both_mode", MODE, 2);
        btn_speed = 1'b0; btn_mode = 1'b0;
        run(10, first, nchg);

        // Same stimulus while locked: nothing changes.
        lock = 1'b1;
        btn_speed = 1'b1; btn_mode = 1'b1;
        run(12, first, nchg);
        chk("lock_nchg", nchg, 0);
        chk("lock_select", Select, 2);
        chk("lock_mode", MODE, 2);
        // Unlocking while still held must not replay the consumed accept.
        lock = 1'b0;
        run(10, first, nchg);
        chk("unlock_held_nchg", nchg, 0);
        btn_speed = 1'b0; btn_mode = 1'b0;
        run(10, first, nchg);

        // Reset asserted at edge 3 of a held press, released at edge 5.
        btn_speed = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("midrst_select", Select, 0);
        chk("midrst_mode", MODE, 0);
        chk("midrst_changed", changed, 0);
        reset = 1'b1;
        run(12, first, nchg);
        chk("midrst_edge", first, 6);
        chk("midrst_nchg", nchg, 1);
        chk("midrst_select2", Select, 1);
        btn_speed = 1'b0;
        run(10, first, nchg);
`else
        // Auto-advance every 50 idle cycles.
        wait_chg(200, nchg);
        chk("auto1_cycles", nchg, 50);
        chk("auto1_mode", MODE, 1);
        wait_chg(200, nchg);
        chk("auto2_cycles", nchg, 50);
        chk("auto2_mode", MODE, 2);
        // Button accept 30 cycles after the last step restarts the period.
        repeat (24) tick();
        btn_mode = 1'b1;
        wait_chg(20, nchg);
        chk("acc_cycles", nchg, 7);
        chk("acc_mode", MODE, 3);
        wait_chg(200, nchg);
        chk("auto3_cycles", nchg, 50);
        chk("auto3_mode", MODE, 0);
        chk("auto3_select", Select, 0);
        btn_mode = 1'b0;
        // Locked: timer holds, no step.
        lock = 1'b1;
        run(120, first, nchg);
        chk("auto_lock_nchg", nchg, 0);
        chk("auto_lock_mode", MODE, 0);
        lock = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
